// File: rtl/scan_shift_engine_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
//   Shared definitions for the scan shift engine: FSM state encoding and the
//   helper that sizes the bits-remaining counter.
// -----------------------------------------------------------------------------
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself (loaded at capture), hence +1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/scan_shift_engine_core.sv
// -----------------------------------------------------------------------------
// scan_shift_core
//   Capture/shift register with a direction mux.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     i_load       capture i_par into the shift register (priority over shift)
//     i_shift      advance one bit, taking i_ser in at the far end
//     i_ser        serial input bit
//     i_par        parallel word to capture
//     o_bit        bit currently presented at the outgoing end
//     o_next       value the register takes on a shift (used for the update)
// -----------------------------------------------------------------------------
module scan_shift_core #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_ser,
    input  logic [WIDTH-1:0] i_par,
    output logic             o_bit,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_next;
    logic             w_bit;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_next = {r_shreg[WIDTH-2:0], i_ser};
            assign w_bit  = r_shreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_next = {i_ser, r_shreg[WIDTH-1:1]};
            assign w_bit  = r_shreg[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_par;
        end else if (i_shift) begin
            r_shreg <= w_next;
        end
    end

    assign o_bit  = w_bit;
    assign o_next = w_next;

endmodule

// File: rtl/scan_shift_engine.sv
// -----------------------------------------------------------------------------
// scan_shift_engine
//   Capture/shift/update scan register between the SoC and a serial chain.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        capture par_in and begin a scan (IDLE or DONE only)
//     par_in       SoC word to capture
//     shift_en     advance one bit this cycle (SHIFT only)
//     ser_in       serial data into the far end of the chain
//     abort        cancel the scan in progress, no update
//     ser_out      outgoing bit, 0 outside SHIFT
//     par_out      update register, last fully received word
//     busy         high while in SHIFT
//     done         one-cycle strobe, par_out just loaded
//     bits_left    bits remaining in the current scan, 0 when idle
//     dbg_state    current FSM state
//   Handshake: start is sampled on the rising edge and only acted on in IDLE or
//   DONE; shift_en is a per-cycle enable with no back-pressure, any stall
//   length is allowed; done is a strobe with no acknowledge.
// -----------------------------------------------------------------------------
module scan_shift_engine
    import scan_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] par_in,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic             abort,
    output logic             ser_out,
    output logic [WIDTH-1:0] par_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bits_left,
    output state_t           dbg_state
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_bits_left;
    logic [WIDTH-1:0] r_par_out;
    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic             w_bit;
    logic [WIDTH-1:0] w_next;

    scan_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_ser   (ser_in),
        .i_par   (par_in),
        .o_bit   (w_bit),
        .o_next  (w_next)
    );

    // Final shift of the scan: this edge also commits the update register.
    assign w_last = w_shift && (r_bits_left == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // abort outranks shift_en; start is ignored here.
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (shift_en) begin
                    w_shift = 1'b1;
                    if (r_bits_left == CNT_W'(1)) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // start here gives back-to-back scans with no idle gap.
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bits_left <= '0;
        end else if (w_load) begin
            r_bits_left <= CNT_W'(WIDTH);
        end else if ((r_state == ST_SHIFT) && abort) begin
            r_bits_left <= '0;
        end else if (w_shift && (r_bits_left != '0)) begin
            r_bits_left <= r_bits_left - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_out <= '0;
        end else if (w_last) begin
            r_par_out <= w_next;
        end
    end

    assign busy      = (r_state == ST_SHIFT);
    assign done      = (r_state == ST_DONE);
    assign ser_out   = busy & w_bit;
    assign par_out   = r_par_out;
    assign bits_left = r_bits_left;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_scan_shift_engine.sv
module tb_scan_shift_engine;
    import scan_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // shared stimulus; ser_in is separate per instance
    logic         start, shift_en, abort, si0, si1;
    logic [W-1:0] par_in;

    logic          so0, so1, busy0, busy1, done0, done1;
    logic [W-1:0]  pout0, pout1;
    logic [CW-1:0] bl0, bl1;
    state_t        st0, st1;

    scan_shift_engine #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .par_in(par_in),
        .shift_en(shift_en), .ser_in(si0), .abort(abort),
        .ser_out(so0), .par_out(pout0), .busy(busy0), .done(done0),
        .bits_left(bl0), .dbg_state(st0)
    );

    scan_shift_engine #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .par_in(par_in),
        .shift_en(shift_en), .ser_in(si1), .abort(abort),
        .ser_out(so1), .par_out(pout1), .busy(busy1), .done(done1),
        .bits_left(bl1), .dbg_state(st1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [W-1:0] p, input logic se,
                         input logic s0, input logic s1, input logic ab);
        start    = st;
        par_in   = p;
        shift_en = se;
        si0      = s0;
        si1      = s1;
        abort    = ab;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          start;
        logic [W-1:0]  par_in;
        logic          shift_en;
        logic          si0;
        logic          si1;
        logic          abort;
        logic          e_so;
        logic          e_busy;
        logic          e_done;
        logic [CW-1:0] e_bl;
        logic [W-1:0]  e_pout0;
        logic [W-1:0]  e_pout1;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // dut0 receives 8'h3C LSB-first, dut1 receives 8'h81 MSB-first,
        // both present 8'hA5 as 1,0,1,0,0,1,0,1. Outputs checked after each edge.
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 8'h00, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 8'h00, 8'h00};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h3C, 8'h81};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3C, 8'h81};
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_busy0", 32'(busy0), 32'd0);
        check("reset_done0", 32'(done0), 32'd0);
        check("reset_so0", 32'(so0), 32'd0);
        check("reset_bl0", 32'(bl0), 32'd0);
        check("reset_pout0", 32'(pout0), 32'd0);
        check("reset_state0", 32'(st0), 32'(ST_IDLE));
        check("reset_bl1", 32'(bl1), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // tests 1 and 2: table-driven scan (last row also shows abort ignored in IDLE)
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].start, vecs[i].par_in, vecs[i].shift_en,
                  vecs[i].si0, vecs[i].si1, vecs[i].abort);
            tick();
            check($sformatf("v%0d_so0", i), 32'(so0), 32'(vecs[i].e_so));
            check($sformatf("v%0d_so1", i), 32'(so1), 32'(vecs[i].e_so));
            check($sformatf("v%0d_busy0", i), 32'(busy0), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_busy1", i), 32'(busy1), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_done0", i), 32'(done0), 32'(vecs[i].e_done));
            check($sformatf("v%0d_done1", i), 32'(done1), 32'(vecs[i].e_done));
            check($sformatf("v%0d_bl0", i), 32'(bl0), 32'(vecs[i].e_bl));
            check($sformatf("v%0d_bl1", i), 32'(bl1), 32'(vecs[i].e_bl));
            check($sformatf("v%0d_pout0", i), 32'(pout0), 32'(vecs[i].e_pout0));
            check($sformatf("v%0d_pout1", i), 32'(pout1), 32'(vecs[i].e_pout1));
        end

        // test 3: shift_en toggling, 8 enabled cycles over 15 edges after start
        drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("tog_bl_start", 32'(bl0), 32'd8);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            shift_en = (i % 2 == 0);
            tick();
            if (i < 14) begin
                check($sformatf("tog%0d_bl", i), 32'(bl0), 32'(7 - i / 2));
                check($sformatf("tog%0d_busy", i), 32'(busy0), 32'd1);
                check($sformatf("tog%0d_done", i), 32'(done0), 32'd0);
            end else begin
                check("tog_done", 32'(done0), 32'd1);
                check("tog_pout0", 32'(pout0), 32'hFF);
                check("tog_pout1", 32'(pout1), 32'h00);
            end
        end
        shift_en = 1'b0;
        tick();
        check("tog_idle_done", 32'(done0), 32'd0);

        // test 4: abort together with shift_en at bits_left=3
        drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        start    = 1'b0;
        shift_en = 1'b1;
        repeat (5) tick();
        check("abort_pre_bl", 32'(bl0), 32'd3);
        abort = 1'b1;
        tick();
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        check("abort_bl", 32'(bl0), 32'd0);
        check("abort_pout0", 32'(pout0), 32'hFF);
        check("abort_pout1", 32'(pout1), 32'h00);
        check("abort_state", 32'(st0), 32'(ST_IDLE));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("abort_no_done", 32'(done0), 32'd0);

        // test 5: start in DONE cycle, start during SHIFT ignored
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        start    = 1'b0;
        shift_en = 1'b1;
        repeat (8) tick();
        check("b2b_done", 32'(done0), 32'd1);
        check("b2b_pout0", 32'(pout0), 32'h00);
        drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("b2b_busy", 32'(busy0), 32'd1);
        check("b2b_bl", 32'(bl0), 32'd8);
        check("b2b_so", 32'(so0), 32'd1);
        drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("ign_start_bl", 32'(bl0), 32'd7);
        check("ign_start_so0", 32'(so0), 32'd1);
        check("ign_start_so1", 32'(so1), 32'd1);

        // test 6: asynchronous reset mid-scan at bits_left=5, then clean scan
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        check("rst_pre_bl", 32'(bl0), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_so", 32'(so0), 32'd0);
        check("arst_bl", 32'(bl0), 32'd0);
        check("arst_pout0", 32'(pout0), 32'd0);
        check("arst_pout1", 32'(pout1), 32'd0);
        check("arst_state", 32'(st0), 32'(ST_IDLE));
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("post_rst_bl", 32'(bl0), 32'd8);
        check("post_rst_so0", 32'(so0), 32'd0);
        check("post_rst_so1", 32'(so1), 32'd1);
        start    = 1'b0;
        shift_en = 1'b1;
        repeat (8) tick();
        check("post_rst_done", 32'(done0), 32'd1);
        check("post_rst_pout0", 32'(pout0), 32'hFF);
        check("post_rst_pout1", 32'(pout1), 32'hFF);
        shift_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
